vector_spad_resp: RTL and testbench



---
 rtl/vector_pkg.sv | 42 ++++
 rtl/vspad_addr_gen.sv | 49 ++++
 rtl/vector_spad_resp.sv | 193 +++++++++++++++++++
 tb/tb_vector_spad_resp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// vector_pkg: shared types and defaults for the vector scratchpad path.
//   vreg_t      - one vector register, NUM_ELEMENTS FP16 lanes, element 0 in the LSBs
//   vsel_t      - vector register tag
//   dtype_t     - element type carried on a request
//   spad_err_t  - one-hot names for the 5 response error flags (flags OR together)
//   spad_state_t- request FSM states
package vector_pkg;
  localparam int NUM_ELEMENTS   = 16;
  localparam int ELEM_W         = 16;
  localparam int NUM_VREGS      = 32;
  localparam int DEF_BEAT_ELEMS = 4;
  localparam int DEF_SP_ROWS    = 64;
  localparam int DEF_SP_COLS    = 64;
  localparam int COORD_W        = 12;
  localparam int ERR_W          = 5;

  typedef logic [NUM_ELEMENTS-1:0][ELEM_W-1:0] vreg_t;
  typedef logic [$clog2(NUM_VREGS)-1:0]        vsel_t;

  typedef enum logic [1:0] {
    DT_FP16 = 2'd0,
    DT_BF16 = 2'd1,
    DT_FP32 = 2'd2,
    DT_INT8 = 2'd3
  } dtype_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE  = 5'h00,
    ERR_ROW   = 5'h01,
    ERR_COL   = 5'h02,
    ERR_ALIGN = 5'h04,
    ERR_DTYPE = 5'h08,
    ERR_RSVD  = 5'h10
  } spad_err_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESP   = 2'd3
  } spad_state_t;
endpackage

// File: rtl/vspad_addr_gen.sv
// vspad_addr_gen: combinational word address and range/format check.
//   row, col  - element coordinate of vector element 0
//   swizzle   - 1: column-stride (each beat moves down one row)
//   datatype  - element type, only FP16 is legal
//   beat      - beat index within the vector
//   addr      - scratchpad word address for this beat (truncated)
//   err       - error flags, see spad_err_t
module vspad_addr_gen
  import vector_pkg::*;
#(
  parameter int NUM_ELEMS = NUM_ELEMENTS,
  parameter int BEAT_ELEMS = DEF_BEAT_ELEMS,
  parameter int SP_ROWS    = DEF_SP_ROWS,
  parameter int SP_COLS    = DEF_SP_COLS,
  parameter int BW         = 2
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               swizzle,
  input  dtype_t             datatype,
  input  logic [BW-1:0]      beat,
  output logic [COORD_W-1:0] addr,
  output logic [ERR_W-1:0]   err
);
  localparam int NUM_BEATS     = NUM_ELEMS / BEAT_ELEMS;
  localparam int WORDS_PER_ROW = SP_COLS / BEAT_ELEMS;

  logic [31:0] row_w, col_w, beat_w;

  always_comb begin
    row_w = 32'(row);
    col_w = 32'(col);
    beat_w = 32'(beat);
    if (swizzle) addr = COORD_W'((row_w + beat_w) * WORDS_PER_ROW + col_w / BEAT_ELEMS);
    else         addr = COORD_W'(row_w * WORDS_PER_ROW + col_w / BEAT_ELEMS + beat_w);

    err = ERR_NONE;
    if (swizzle) begin
      // swizzle footprint: NUM_BEATS rows by one word
      if (row_w + 32'(NUM_BEATS) > 32'(SP_ROWS))  err = err | ERR_ROW;
      if (col_w + 32'(BEAT_ELEMS) > 32'(SP_COLS)) err = err | ERR_COL;
    end else begin
      if (row_w >= 32'(SP_ROWS))                 err = err | ERR_ROW;
      if (col_w + 32'(NUM_ELEMS) > 32'(SP_COLS)) err = err | ERR_COL;
    end
    if ((col_w % BEAT_ELEMS) != 0) err = err | ERR_ALIGN;
    if (datatype != DT_FP16)       err = err | ERR_DTYPE;
  end
endmodule

// File: rtl/vector_spad_resp.sv
// vector_spad_resp: vector-register <-> scratchpad load/store engine.
//   req_*   - one vector request (load or store), accepted only in IDLE
//   rsp_*   - one response per accepted request, held until rsp_ready
//   sram_*  - single-port word SRAM, read data valid the cycle after sram_en
// A vector is moved as NUM_BEATS word beats, one per cycle. Bad requests
// answer immediately with error flags and never touch the SRAM.
module vector_spad_resp
  import vector_pkg::*;
#(
  parameter int NUM_ELEMENTS = vector_pkg::NUM_ELEMENTS,
  parameter int BEAT_ELEMS   = DEF_BEAT_ELEMS,
  parameter int SP_ROWS      = DEF_SP_ROWS,
  parameter int SP_COLS      = DEF_SP_COLS
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wen,
  input  vsel_t                        req_vd,
  input  vreg_t                        req_vdata,
  input  logic [NUM_ELEMENTS-1:0]      req_vmask,
  input  logic [COORD_W-1:0]           req_row,
  input  logic [COORD_W-1:0]           req_col,
  input  logic                         req_swizzle,
  input  dtype_t                       req_datatype,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output vsel_t                        rsp_vd,
  output logic                         rsp_wen,
  output vreg_t                        rsp_vdata,
  output logic [ERR_W-1:0]             rsp_error,
  output logic                         sram_en,
  output logic                         sram_we,
  output logic [COORD_W-1:0]           sram_addr,
  output logic [BEAT_ELEMS*ELEM_W-1:0] sram_wdata,
  output logic [BEAT_ELEMS-1:0]        sram_wmask,
  input  logic [BEAT_ELEMS*ELEM_W-1:0] sram_rdata
);
  localparam int NUM_BEATS = NUM_ELEMENTS / BEAT_ELEMS;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  spad_state_t             state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    wen_q, wen_d;
  vsel_t                   vd_q, vd_d;
  vreg_t                   vdata_q, vdata_d;
  logic [NUM_ELEMENTS-1:0] vmask_q, vmask_d;
  logic [COORD_W-1:0]      row_q, row_d, col_q, col_d;
  logic                    swz_q, swz_d;
  dtype_t                  dt_q, dt_d;
  logic [ERR_W-1:0]        err_q, err_d;
  vreg_t                   rbuf_q, rbuf_d;

  logic                    idle, hs, last_beat, cap_en;
  logic [BW-1:0]           cap_beat;
  logic [BEAT_ELEMS-1:0]   beat_mask;
  logic [COORD_W-1:0]      ag_row, ag_col, ag_addr;
  logic                    ag_swz;
  dtype_t                  ag_dt;
  logic [ERR_W-1:0]        ag_err;

  assign idle      = (state_q == S_IDLE);
  assign hs        = req_valid & idle;
  assign last_beat = (beat_q == BW'(NUM_BEATS - 1));
  assign beat_mask = vmask_q[int'(beat_q)*BEAT_ELEMS +: BEAT_ELEMS];

  // The error decision is needed on the handshake cycle itself, so in IDLE
  // the checker looks at the live request; afterwards at the registered one.
  assign ag_row = idle ? req_row      : row_q;
  assign ag_col = idle ? req_col      : col_q;
  assign ag_swz = idle ? req_swizzle  : swz_q;
  assign ag_dt  = idle ? req_datatype : dt_q;

  vspad_addr_gen #(
    .NUM_ELEMS (NUM_ELEMENTS),
    .BEAT_ELEMS(BEAT_ELEMS),
    .SP_ROWS   (SP_ROWS),
    .SP_COLS   (SP_COLS),
    .BW        (BW)
  ) u_addr_gen (
    .row     (ag_row),
    .col     (ag_col),
    .swizzle (ag_swz),
    .datatype(ag_dt),
    .beat    (beat_q),
    .addr    (ag_addr),
    .err     (ag_err)
  );

  // Load data for beat k arrives while beat k+1 issues; the final beat's
  // data lands in DRAIN, where the counter has already wrapped to 0.
  assign cap_en   = ~wen_q & (((state_q == S_ACCESS) & (beat_q != '0)) | (state_q == S_DRAIN));
  assign cap_beat = beat_q - BW'(1);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wen_d   = wen_q;
    vd_d    = vd_q;
    vdata_d = vdata_q;
    vmask_d = vmask_q;
    row_d   = row_q;
    col_d   = col_q;
    swz_d   = swz_q;
    dt_d    = dt_q;
    err_d   = err_q;
    rbuf_d  = rbuf_q;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;

    case (state_q)
      S_IDLE: if (hs) begin
        wen_d   = req_wen;
        vd_d    = req_vd;
        vdata_d = req_vdata;
        vmask_d = req_vmask;
        row_d   = req_row;
        col_d   = req_col;
        swz_d   = req_swizzle;
        dt_d    = req_datatype;
        err_d   = ag_err;
        rbuf_d  = '0;
        beat_d  = '0;
        state_d = (ag_err != '0) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        sram_addr = ag_addr;
        if (wen_q) begin
          // a fully masked beat still occupies its slot, just without a strobe
          sram_en    = |beat_mask;
          sram_we    = 1'b1;
          sram_wmask = beat_mask;
          sram_wdata = vdata_q[int'(beat_q)*BEAT_ELEMS +: BEAT_ELEMS];
        end else begin
          sram_en = 1'b1;
        end
        beat_d = beat_q + BW'(1);
        if (last_beat) state_d = wen_q ? S_RESP : S_DRAIN;
      end
      S_DRAIN: state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cap_en) begin
      for (int j = 0; j < BEAT_ELEMS; j++) begin
        rbuf_d[int'(cap_beat)*BEAT_ELEMS + j] =
          vmask_q[int'(cap_beat)*BEAT_ELEMS + j] ? sram_rdata[j*ELEM_W +: ELEM_W] : '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      wen_q   <= 1'b0;
      vd_q    <= '0;
      vdata_q <= '0;
      vmask_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      swz_q   <= 1'b0;
      dt_q    <= DT_FP16;
      err_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wen_q   <= wen_d;
      vd_q    <= vd_d;
      vdata_q <= vdata_d;
      vmask_q <= vmask_d;
      row_q   <= row_d;
      col_q   <= col_d;
      swz_q   <= swz_d;
      dt_q    <= dt_d;
      err_q   <= err_d;
      rbuf_q  <= rbuf_d;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_vd    = vd_q;
  assign rsp_wen   = wen_q;
  assign rsp_vdata = rbuf_q;
  assign rsp_error = err_q;
endmodule

// File: tb/tb_vector_spad_resp.sv
// tb_vector_spad_resp: random and directed requests against an element-grid
// model of the scratchpad; an SRAM stub backs the DUT's word port.
module tb_vector_spad_resp;
  import vector_pkg::*;

  localparam int NE = 16, BE = 4, NB = NE / BE, ROWS = 64, COLS = 64, WPR = COLS / BE;

  typedef struct {
    logic          wen;
    vsel_t         vd;
    vreg_t         vdata;
    logic [NE-1:0] vmask;
    logic [11:0]   row, col;
    logic          swz;
    dtype_t        dt;
  } req_t;

  logic CLK = 1'b0, RST = 1'b0;
  always #5 CLK = ~CLK;

  logic req_valid, req_ready, req_wen, req_swizzle, rsp_valid, rsp_ready, rsp_wen;
  vsel_t req_vd, rsp_vd;
  vreg_t req_vdata, rsp_vdata;
  logic [NE-1:0] req_vmask;
  logic [11:0] req_row, req_col, sram_addr;
  dtype_t req_datatype;
  logic [4:0] rsp_error;
  logic sram_en, sram_we;
  logic [63:0] sram_wdata, sram_rdata;
  logic [3:0] sram_wmask;

  vector_spad_resp dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_vd(req_vd),
    .req_vdata(req_vdata), .req_vmask(req_vmask), .req_row(req_row), .req_col(req_col),
    .req_swizzle(req_swizzle), .req_datatype(req_datatype),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vd(rsp_vd), .rsp_wen(rsp_wen),
    .rsp_vdata(rsp_vdata), .rsp_error(rsp_error),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  // SRAM stub; read data is noise unless a read was issued last cycle
  logic [63:0] mem [4096];
  always @(posedge CLK) begin
    if (sram_en && sram_we)
      for (int j = 0; j < BE; j++)
        if (sram_wmask[j]) mem[sram_addr][16*j +: 16] <= sram_wdata[16*j +: 16];
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    else                     sram_rdata <= {$urandom, $urandom};
  end

  // reference: the scratchpad as a 2-D grid of FP16 elements
  logic [15:0] grid [ROWS][COLS];
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic elem_rc(input req_t t, input int i, output int r, output int c);
    if (t.swz) begin r = int'(t.row) + i / BE; c = int'(t.col) + i % BE; end
    else       begin r = int'(t.row);          c = int'(t.col) + i;      end
  endtask

  function automatic logic [4:0] exp_err(input req_t t);
    int r, c;
    logic [4:0] e;
    r = int'(t.row);
    c = int'(t.col);
    e = '0;
    if (t.swz) begin e[0] = (r + NB > ROWS); e[1] = (c + BE > COLS); end
    else       begin e[0] = (r >= ROWS);     e[1] = (c + NE > COLS); end
    e[2] = (c % BE) != 0;
    e[3] = (t.dt != DT_FP16);
    return e;
  endfunction

  task automatic drive_req(input req_t t);
    req_wen = t.wen; req_vd = t.vd; req_vdata = t.vdata; req_vmask = t.vmask;
    req_row = t.row; req_col = t.col; req_swizzle = t.swz; req_datatype = t.dt;
  endtask

  function automatic req_t rand_req();
    req_t t;
    t.wen = 1'($urandom_range(0, 1));
    t.vd = vsel_t'($urandom);
    for (int i = 0; i < NE; i++) t.vdata[i] = 16'($urandom);
    t.vmask = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'($urandom);
    t.swz = 1'($urandom_range(0, 1));
    t.row = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, t.swz ? 60 : 63));
    t.col = 12'(4 * $urandom_range(0, t.swz ? 15 : 12));
    case ($urandom_range(0, 11))
      0: t.col = 12'($urandom);
      1: t.col = t.col + 12'($urandom_range(1, 3));
      default: ;
    endcase
    t.dt = ($urandom_range(0, 7) == 0) ? dtype_t'($urandom_range(1, 3)) : DT_FP16;
    return t;
  endfunction

  task automatic noise();
    req_t n;
    n = rand_req();
    drive_req(n);
    req_valid = 1'b1;
  endtask

  task automatic run_txn(input req_t t, input bit noisy, input bit early, input int hold);
    logic [4:0] eerr;
    int R, r, c;
    vreg_t ev;
    logic [3:0] emask;
    logic [63:0] ewd;
    eerr = exp_err(t);
    R = (eerr != 0) ? 1 : (t.wen ? NB + 1 : NB + 2);
    ev = '0;
    if (eerr == 0 && !t.wen)
      for (int i = 0; i < NE; i++) begin
        elem_rc(t, i, r, c);
        if (t.vmask[i]) ev[i] = grid[r][c];
      end
    @(negedge CLK);
    drive_req(t);
    req_valid = 1'b1;
    chk("req_ready_idle", 256'(req_ready), 256'(1));
    for (int cyc = 1; cyc <= R; cyc++) begin
      @(negedge CLK);
      if (cyc < R) begin
        chk("busy", 256'({rsp_valid, req_ready}), 256'(0));
        if (eerr == 0 && cyc <= NB) begin
          elem_rc(t, (cyc - 1) * BE, r, c);
          emask = t.vmask[(cyc-1)*BE +: BE];
          chk("beat_ctl", 256'({sram_en, sram_we, sram_addr}),
              256'({t.wen ? |emask : 1'b1, t.wen, 12'(r * WPR + c / BE)}));
          if (t.wen) begin
            ewd = t.vdata[(cyc-1)*BE +: BE];
            chk("beat_wr", 256'({sram_wmask, sram_wdata}), 256'({emask, ewd}));
          end
        end else begin
          chk("sram_quiet", 256'({sram_en, sram_we, sram_wmask}), 256'(0));
        end
      end else begin
        chk("rsp_valid", 256'({rsp_valid, req_ready, sram_en, sram_we, sram_wmask}), 256'(8'b1000_0000));
        chk("rsp_hdr", 256'({rsp_vd, rsp_wen, rsp_error}), 256'({t.vd, t.wen, eerr}));
        chk("rsp_vdata", rsp_vdata, ev);
      end
      if (noisy) noise(); else req_valid = 1'b0;
      if (cyc == 1) rsp_ready = early;
    end
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        chk("hold_state", 256'({rsp_valid, req_ready, sram_en}), 256'(3'b100));
        chk("hold_hdr", 256'({rsp_vd, rsp_wen, rsp_error}), 256'({t.vd, t.wen, eerr}));
        chk("hold_vdata", rsp_vdata, ev);
        if (noisy) noise();
      end
      rsp_ready = 1'b1;
    end
    @(negedge CLK);
    chk("post_rsp", 256'({rsp_valid, req_ready}), 256'(2'b01));
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (t.wen && eerr == 0)
      for (int i = 0; i < NE; i++) begin
        elem_rc(t, i, r, c);
        if (t.vmask[i]) grid[r][c] = t.vdata[i];
      end
  endtask

  function automatic req_t mk(input logic wen, input int row, input int col, input logic swz,
                              input logic [NE-1:0] vmask, input dtype_t dt);
    req_t t;
    t.wen = wen; t.vd = vsel_t'(row + col); t.row = 12'(row); t.col = 12'(col);
    t.swz = swz; t.vmask = vmask; t.dt = dt;
    for (int i = 0; i < NE; i++) t.vdata[i] = 16'(i);
    return t;
  endfunction

  initial begin
    req_t t;
    logic [63:0] w;
    n_cmp = 0;
    n_err = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_wen = 1'b0; req_vd = '0; req_vdata = '0; req_vmask = '0;
    req_row = '0; req_col = '0; req_swizzle = 1'b0; req_datatype = DT_FP16;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 16'($urandom);
    for (int a = 0; a < 4096; a++) begin
      w = '0;
      if (a < ROWS * WPR)
        for (int l = 0; l < BE; l++) w[16*l +: 16] = grid[a / WPR][(a % WPR) * BE + l];
      mem[a] <= w;
    end

    #2 RST = 1'b1;
    #1;
    chk("reset_ctl", 256'({rsp_valid, rsp_error, rsp_vd, rsp_wen, sram_en, sram_we,
                           sram_wmask, sram_addr, sram_wdata}), 256'(0));
    chk("reset_vdata", rsp_vdata, 256'(0));
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_ready", 256'({req_ready, rsp_valid}), 256'(2'b10));

    // directed: store/load pair, swizzle, each error flag, long back-pressure
    run_txn(mk(1'b1, 2, 8, 1'b0, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b0, 2, 8, 1'b0, 16'h00FF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b1, 10, 4, 1'b1, 16'hF0F5, DT_FP16), 1'b0, 1'b0, 1);
    run_txn(mk(1'b0, 10, 4, 1'b1, 16'hFFFF, DT_FP16), 1'b0, 1'b1, 0);
    run_txn(mk(1'b0, 64, 0, 1'b0, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b0, 1, 6, 1'b0, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b0, 1, 56, 1'b0, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b0, 1, 0, 1'b0, 16'hFFFF, DT_BF16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b1, 61, 60, 1'b1, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);
    run_txn(mk(1'b1, 60, 60, 1'b1, 16'h0FF0, DT_FP16), 1'b1, 1'b0, 5);
    run_txn(mk(1'b0, 60, 60, 1'b1, 16'hFFFF, DT_FP16), 1'b1, 1'b0, 5);
    run_txn(mk(1'b1, 63, 48, 1'b0, 16'h8001, DT_FP16), 1'b0, 1'b1, 0);

    for (int n = 0; n < 80; n++)
      run_txn(rand_req(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 3));

    // reset in cycle 3 of a store: beats 0 and 1 stay written, no response
    t = mk(1'b1, 20, 8, 1'b0, 16'hFFFF, DT_FP16);
    for (int i = 0; i < NE; i++) t.vdata[i] = 16'($urandom);
    @(negedge CLK);
    drive_req(t);
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    chk("pre_rst_beat", 256'({sram_en, sram_addr}), 256'({1'b1, 12'(20 * WPR + 2 + 2)}));
    RST = 1'b1;
    #1;
    chk("rst_ctl", 256'({rsp_valid, rsp_error, rsp_vd, rsp_wen, sram_en, sram_we,
                         sram_wmask, sram_addr, sram_wdata}), 256'(0));
    chk("rst_vdata", rsp_vdata, 256'(0));
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst", 256'({req_ready, rsp_valid, sram_en}), 256'(3'b100));
    end
    for (int i = 0; i < 2 * BE; i++) grid[20][8 + i] = t.vdata[i];
    run_txn(mk(1'b0, 20, 8, 1'b0, 16'hFFFF, DT_FP16), 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
